// File: rtl/dpll_fll_controller_if.sv
// Signal bundle between the FLL controller and its environment.
// The slave side is the controller; the master side drives the loop inputs.
interface dpll_fll_controller_if #(
   parameter int unsigned TRIM_W = 26,
   parameter int unsigned DIV_W  = 5
);
   localparam int unsigned TV_W = $clog2(TRIM_W + 1);

   logic              enable;
   logic              osc;
   logic [DIV_W-1:0]  div;
   logic              manual_en;
   logic [TV_W-1:0]   manual_tval;
   logic [TRIM_W-1:0] trim;
   logic [TV_W-1:0]   tval;
   logic              locked;

   modport master (
      output enable, osc, div, manual_en, manual_tval,
      input  trim, tval, locked
   );

   modport slave (
      input  enable, osc, div, manual_en, manual_tval,
      output trim, tval, locked
   );
endinterface

// File: rtl/dpll_fll_controller.sv
// Second-generation frequency-locked-loop controller for the digital PLL.
// Counts ring-oscillator cycles per reference period and steers a
// thermometer trim word so the count converges on the requested ratio.
module dpll_fll_controller #(
   parameter int unsigned TRIM_W    = 26,
   parameter int unsigned DIV_W     = 5,
   parameter int unsigned LOCK_CNT  = 4,
   parameter int unsigned INIT_TVAL = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   dpll_fll_controller_if.slave  bus
);
   localparam int unsigned CNT_W = DIV_W + 1;
   localparam int unsigned TV_W  = $clog2(TRIM_W + 1);
   localparam int unsigned LC_W  = $clog2(LOCK_CNT + 1);

   localparam logic [TV_W-1:0]  TV_MAX  = TV_W'(TRIM_W);
   localparam logic [TV_W-1:0]  TV_INIT = TV_W'(INIT_TVAL);
   localparam logic [TV_W-1:0]  TV_ONE  = TV_W'(1);
   localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_CNT);
   localparam logic [LC_W-1:0]  LC_ONE  = LC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   X_ONE   = (CNT_W + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACQ,
      ST_TRACK,
      ST_MANUAL
   } state_t;

   function automatic logic [TRIM_W-1:0] therm(input logic [TV_W-1:0] v);
      logic [TRIM_W-1:0] t;
      t = '0;
      for (int unsigned i = 0; i < TRIM_W; i++) begin
         t[i] = (TV_W'(i) < v);
      end
      return t;
   endfunction

   logic              osc_s1_q, osc_s2_q, osc_h_q;
   logic              ref_edge;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TV_W-1:0]   tval_q, tval_d;
   logic [LC_W-1:0]   lc_q, lc_d;
   logic              locked_q, locked_d;
   logic [TRIM_W-1:0] trim_q, trim_d;

   logic [CNT_W:0]    m_x, div_x;
   logic              too_fast, too_slow, in_tol;
   logic [TV_W-1:0]   manual_clamp;

   // Two-stage synchroniser for the reference plus a history stage for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         osc_s1_q <= 1'b0;
         osc_s2_q <= 1'b0;
         osc_h_q  <= 1'b0;
      end else begin
         osc_s1_q <= bus.osc;
         osc_s2_q <= osc_s1_q;
         osc_h_q  <= osc_s2_q;
      end
   end

   assign ref_edge = osc_s2_q & ~osc_h_q;

   // Compare the measured period against the target ratio (one extra bit avoids overflow in the +1 tolerance).
   always_comb begin
      m_x          = {1'b0, cnt_q};
      div_x        = (CNT_W + 1)'(bus.div);
      too_fast     = (m_x > div_x);
      too_slow     = (m_x < div_x);
      in_tol       = (m_x <= div_x + X_ONE) && (div_x <= m_x + X_ONE);
      manual_clamp = (bus.manual_tval > TV_MAX) ? TV_MAX : bus.manual_tval;
   end

   // Next-state, period counter, trim and lock-counter update.
   always_comb begin
      state_d = state_q;
      tval_d  = tval_q;
      lc_d    = lc_q;
      cnt_d   = cnt_q;

      if (ref_edge) begin
         cnt_d = CNT_ONE;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (!bus.enable) begin
         state_d = ST_IDLE;
         tval_d  = TV_INIT;
         lc_d    = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQ;
               cnt_d   = '0;
            end
            ST_ACQ: begin
               if (bus.manual_en) begin
                  state_d = ST_MANUAL;
                  tval_d  = manual_clamp;
                  lc_d    = '0;
               end else if (ref_edge) begin
                  state_d = ST_TRACK;
               end
            end
            ST_TRACK: begin
               // Manual entry wins over a coincident reference edge, which is dropped.
               if (bus.manual_en) begin
                  state_d = ST_MANUAL;
                  tval_d  = manual_clamp;
                  lc_d    = '0;
               end else if (ref_edge) begin
                  if (too_fast && (tval_q < TV_MAX)) begin
                     tval_d = tval_q + TV_ONE;
                  end else if (too_slow && (tval_q != '0)) begin
                     tval_d = tval_q - TV_ONE;
                  end
                  if (in_tol) begin
                     if (lc_q != LC_MAX) begin
                        lc_d = lc_q + LC_ONE;
                     end
                  end else begin
                     lc_d = '0;
                  end
               end
            end
            ST_MANUAL: begin
               if (bus.manual_en) begin
                  tval_d = manual_clamp;
                  lc_d   = '0;
               end else begin
                  state_d = ST_ACQ;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      locked_d = (state_d == ST_TRACK) && (lc_d == LC_MAX);
      trim_d   = therm(tval_d);
   end

   // Loop state and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         tval_q   <= TV_INIT;
         lc_q     <= '0;
         locked_q <= 1'b0;
         trim_q   <= therm(TV_INIT);
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tval_q   <= tval_d;
         lc_q     <= lc_d;
         locked_q <= locked_d;
         trim_q   <= trim_d;
      end
   end

   assign bus.tval   = tval_q;
   assign bus.trim   = trim_q;
   assign bus.locked = locked_q;
endmodule

// File: tb/tb_dpll_fll_controller.sv
// Scoreboard bench for dpll_fll_controller: stimulus updates a period-based
// model and queues expected outputs; a monitor checks them when they are due.
module tb_dpll_fll_controller;
   localparam int unsigned TRIM_W    = 26;
   localparam int unsigned DIV_W     = 5;
   localparam int unsigned LOCK_CNT  = 4;
   localparam int unsigned INIT_TVAL = 0;
   localparam int unsigned TV_W      = $clog2(TRIM_W + 1);
   localparam int          CNT_SAT   = 63;

   logic clock = 1'b0;
   logic reset;

   dpll_fll_controller_if #(.TRIM_W(TRIM_W), .DIV_W(DIV_W)) bus ();

   dpll_fll_controller #(
      .TRIM_W(TRIM_W),
      .DIV_W(DIV_W),
      .LOCK_CNT(LOCK_CNT),
      .INIT_TVAL(INIT_TVAL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int tval;
      bit locked;
   } exp_t;

   exp_t sbq[$];
   int   total  = 0;
   int   passed = 0;

   // behavioural model state
   int   m_tval;
   int   m_lock;
   bit   m_manual;
   bit   m_primed;
   int   m_prev;

   function automatic longint trim_of(input int tv);
      return (longint'(1) << tv) - 1;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push_exp(input int at);
      exp_t e;
      e.cyc    = at;
      e.tval   = m_tval;
      e.locked = m_primed && !m_manual && (m_lock == LOCK_CNT);
      sbq.push_back(e);
   endtask

   task automatic model_clear();
      m_tval   = INIT_TVAL;
      m_lock   = 0;
      m_primed = 0;
      m_manual = 0;
      m_prev   = 0;
   endtask

   // Reference rising edge now; period = cycles until the next stimulus action.
   task automatic rise(input int period, input int dv);
      int m;
      bus.div = DIV_W'(dv);
      bus.osc = 1'b1;
      if (!m_manual) begin
         if (m_primed) begin
            m = cyc - m_prev;
            if (m > CNT_SAT) m = CNT_SAT;
            if (m > dv && m_tval < int'(TRIM_W)) m_tval++;
            else if (m < dv && m_tval > 0) m_tval--;
            if (m - dv <= 1 && dv - m <= 1) begin
               if (m_lock < int'(LOCK_CNT)) m_lock++;
            end else begin
               m_lock = 0;
            end
         end
         m_primed = 1;
      end
      m_prev = cyc;
      push_exp(cyc + 3);
      tick(period / 2);
      bus.osc = 1'b0;
      tick(period - period / 2);
   endtask

   task automatic manual_on(input int mt);
      bus.manual_tval = TV_W'(mt);
      bus.manual_en   = 1'b1;
      m_manual = 1;
      m_tval   = (mt > int'(TRIM_W)) ? int'(TRIM_W) : mt;
      m_lock   = 0;
      push_exp(cyc + 1);
      tick(2);
   endtask

   task automatic manual_off();
      bus.manual_en = 1'b0;
      m_manual = 0;
      m_primed = 0;
      m_lock   = 0;
      tick(2);
   endtask

   task automatic disable_enable();
      bus.enable = 1'b0;
      model_clear();
      push_exp(cyc + 1);
      tick(3);
      bus.enable = 1'b1;
      tick(3);
   endtask

   task automatic do_reset();
      #3;
      reset = 1'b1;
      #1;
      check("rst_tval", bus.tval, INIT_TVAL);
      check("rst_trim", bus.trim, trim_of(INIT_TVAL));
      check("rst_locked", bus.locked, 0);
      model_clear();
      tick(2);
      reset = 1'b0;
      tick(3);
   endtask

   // Monitor: compare due expectations, flag any output change nothing predicted.
   logic [TV_W-1:0]   last_tval;
   logic [TRIM_W-1:0] last_trim;
   logic              last_locked;
   exp_t              mon_e;
   always @(negedge clock) begin
      if (!reset) begin
         if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            check("missed_update_cycle", cyc, sbq[0].cyc);
            void'(sbq.pop_front());
         end
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            mon_e = sbq.pop_front();
            check("tval", bus.tval, mon_e.tval);
            check("trim", bus.trim, trim_of(mon_e.tval));
            check("locked", bus.locked, mon_e.locked);
         end else if (bus.tval !== last_tval || bus.trim !== last_trim || bus.locked !== last_locked) begin
            check("stable_tval", bus.tval, last_tval);
            check("stable_trim", bus.trim, last_trim);
            check("stable_locked", bus.locked, last_locked);
         end
      end
      last_tval   = bus.tval;
      last_trim   = bus.trim;
      last_locked = bus.locked;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d expectations pending", sbq.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int cur_div, per, r;
      reset           = 1'b1;
      bus.enable      = 1'b0;
      bus.osc         = 1'b0;
      bus.div         = DIV_W'(8);
      bus.manual_en   = 1'b0;
      bus.manual_tval = '0;
      model_clear();
      #2;
      check("por_tval", bus.tval, INIT_TVAL);
      check("por_trim", bus.trim, trim_of(INIT_TVAL));
      check("por_locked", bus.locked, 0);
      tick(3);
      reset      = 1'b0;
      bus.enable = 1'b1;
      tick(3);

      // climb to 7 then reset mid-track
      repeat (8) rise(10, 8);
      do_reset();

      // too fast: ramp and saturate
      repeat (32) rise(10, 8);
      check("sat_trim_all_ones", bus.trim, trim_of(TRIM_W));

      // too slow from manual 5
      manual_on(5);
      manual_off();
      repeat (8) rise(6, 8);

      // lock, then unlock
      repeat (7) rise(8, 8);
      repeat (2) rise(10, 8);

      // manual clamp and an ignored reference edge
      manual_on(30);
      rise(10, 8);
      manual_off();
      rise(10, 8);

      // stopped reference: saturated measurement, counter restart
      rise(110, 8);
      repeat (3) rise(10, 8);

      // div = 0 always too fast
      repeat (5) rise(5, 0);

      // randomized phase
      cur_div = 8;
      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            manual_on($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) rise($urandom_range(4, 20), cur_div);
            manual_off();
         end else if (r < 6) begin
            disable_enable();
         end else begin
            if ($urandom_range(0, 9) == 0) cur_div = $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) per = $urandom_range(64, 80);
            else if ($urandom_range(0, 3) == 0) per = $urandom_range(4, 40);
            else per = cur_div + $urandom_range(0, 6) - 3;
            if (per < 4) per = 4;
            rise(per, cur_div);
         end
      end

      tick(6);
      check("queue_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dpll_fll_controller.md
# dpll_fll_controller

Parametrised second-generation frequency-locked-loop controller for the digital PLL. It runs on the ring-oscillator output clock and measures the oscillator period against the reference input `osc`, in oscillator cycles per reference period. It steers a thermometer trim word back into the ring oscillator. Compared with the first-generation controller it adds:
- generic trim and divider widths;
- a saturating period counter;
- a lock detector with a programmable qualification count;
- a manual trim override mode.

## Interface
Parameters:
- `TRIM_W`, 26, number of thermometer trim bits driven to the ring oscillator
- `DIV_W`, 5, width of the `div` ratio input
- `LOCK_CNT`, 4, consecutive in-tolerance measurements required to assert `locked` (≥1)
- `INIT_TVAL`, 0, trim code loaded on reset/disable (0..TRIM_W)

Derived widths:
- `CNT_W` = `DIV_W`+1
- `TV_W` = clog2(`TRIM_W`+1)

Ports:
- `clock`  in  1  ring-oscillator clock; the only clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  loop enable; low acts as synchronous loop clear
- `osc`  in  1  reference oscillator, asynchronous to `clock`
- `div`  in  `DIV_W`  target oscillator cycles per reference period
- `manual_en`  in  1  1 = trim driven from `manual_tval`, loop frozen
- `manual_tval`  in  `TV_W`  manual trim code
- `trim`  out  `TRIM_W`  thermometer trim: `trim[i]`=1 for i<`tval`; more bits = slower oscillator
- `tval`  out  `TV_W`  current trim code
- `locked`  out  1  frequency lock indicator

## Operation
- **Reference synchronisation:** `osc` passes through a 2-FF synchroniser plus one history FF. `ref_edge` is a 1-cycle pulse on each synchronised rising edge.
- **Period counter `cnt`** (`CNT_W` bits):
  - loads 1 on the `ref_edge` cycle;
  - otherwise increments;
  - saturates at 2^`CNT_W`−1 and never wraps.
- **Measurement:** on `ref_edge`, m = `cnt` (clock cycles since the previous edge). `div` is zero-extended to `CNT_W` bits for all comparisons.
- **States:**
  - IDLE: `enable`=0. `tval`=`INIT_TVAL`, lock counter 0, `cnt` held at 0. Exit to ACQ when `enable`=1.
  - ACQ: waits for the first `ref_edge`. That edge only restarts `cnt`; no trim adjustment is made. Go to TRACK.
  - TRACK: on each `ref_edge`, the adjustment rules below apply.
  - MANUAL: entered from any non-IDLE state when `manual_en`=1.
    - `tval` = min(`manual_tval`, `TRIM_W`) every cycle.
    - Lock counter cleared.
    - When `manual_en` falls, go to ACQ, keeping the current `tval`.
- **Adjustment rules (TRACK, on `ref_edge`):**
  - m > `div` (oscillator too fast): `tval` +1, saturating at `TRIM_W`.
  - m < `div`: `tval` −1, saturating at 0.
  - m = `div`: `tval` unchanged.
- **Lock detection:**
  - If |m−`div`| ≤ 1, the lock counter increments (saturating at `LOCK_CNT`); otherwise it clears.
  - `locked` = 1 when the lock counter = `LOCK_CNT` and the state is TRACK.
- **Priority:** `reset` > `enable`=0 > `manual_en` > loop update.
- **Edge cases:**
  - `div`=0: every measurement reads as too fast, so `tval` ramps to `TRIM_W`.
  - A saturated m (stopped reference) reads as too fast.

## Timing
- **Reset values:**
  - `tval`=`INIT_TVAL`; `trim` = thermometer of `INIT_TVAL`.
  - `locked`=0; state IDLE; `cnt`=0; synchroniser FFs 0.
- **Input-to-edge latency:** a rising edge on `osc` produces `ref_edge` 2–3 `clock` cycles later.
- **Output latency:** `tval`, `trim` and `locked` are registered and update on the clock edge ending the `ref_edge` cycle. `trim` is a registered decode of the next `tval`, so `trim` and `tval` change together.
- **Manual mode:** `manual_en` takes effect on the next clock edge. A `ref_edge` coincident with `manual_en` rising is ignored.
- **Disable:** `enable` falling clears the loop state on the next edge, regardless of any pending `ref_edge`.
- **Reset mid-operation:** asynchronous return to reset values; no partial update survives.

## Test plan
All scenarios use `TRIM_W`=26, `DIV_W`=5, `LOCK_CNT`=4, `INIT_TVAL`=0.
1. **Reset:** assert `reset` mid-TRACK with `tval`=7 → `trim`=0, `tval`=0 and `locked`=0 immediately (asynchronously). After release with `enable`=1, the first `ref_edge` causes no adjustment.
2. **Too fast:** `div`=8, reference period 10 clocks → `tval` goes 0→1→2… (+1 per reference edge, starting from the second edge). It saturates at 26 with `trim`=all ones, and `locked` stays 0.
3. **Too slow:** manual `tval`=5, then release; `div`=8, period 6 → after the discarded first edge, `tval` goes 4, 3, 2, 1, 0 and then holds at 0.
4. **Lock and unlock:** `div`=8, period 8 → `tval` constant and `locked`=1 after the 4th compared edge. Then period 10 → at that edge `locked`=0 and `tval`+1.
5. **Manual clamp:** `manual_en`=1, `manual_tval`=30 → `tval`=26 and `trim`=all ones next cycle, `locked`=0. A `ref_edge` while in MANUAL leaves `tval` unchanged.
6. **Stopped reference:** hold `osc` low for 100 clocks → `cnt` saturates at 63. The next edge gives m=63 > `div`, so `tval`+1, and `cnt` restarts at 1.
